// File: rtl/self_conv_seq.sv
// self_conv_seq: hardware sequencer for the BIST self-convergence campaign.
// Drives scan_num and a per-run reset into BISG_TOP, waits for over, turns
// the captured speed code into a max-delay value, counts convergence hits
// between consecutive runs and keeps the golden signature / pass flag.
// Optional feature macro: BOUNCE_MULT_EN (each convergence hit doubles the
// following scan_num increment; without it the increment is fixed).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start after reset
// CUT_RST | holding cut_rst_n low for RST_CYC cycles
// ARM     | waiting for a stale over from the previous run to drop
// RUN     | CUT running; capture signatures, wait for over
// EVAL    | one cycle: compute delay, convergence, next scan_num
// DONE    | campaign finished; outputs held until the next start
module self_conv_seq #(
    parameter int SIG_W      = 13,
    parameter int SPEED_W    = 10,
    parameter int SCAN_W     = 20,
    parameter int DLY_W      = 16,
    parameter int SCAN_START = 50,
    parameter int SCAN_STEP  = 10,
    parameter int EPS        = 10,
    parameter int K_THRESH   = 7,
    parameter int MAX_RUNS   = 6,
    parameter int RST_CYC    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               over,
    input  logic               scan_done,
    input  logic [SIG_W-1:0]   sig,
    input  logic [SPEED_W-1:0] speed,
    output logic               cut_rst_n,
    output logic [SCAN_W-1:0]  scan_num,
    output logic               pass,
    output logic [SIG_W-1:0]   golden_sig,
    output logic [DLY_W-1:0]   max_dly,
    output logic [7:0]         run_cnt,
    output logic [7:0]         hit_cnt,
    output logic               busy,
    output logic               converged,
    output logic               done
);

    localparam int RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {IDLE, CUT_RST, ARM, RUN, EVAL, DONE} state_t;

    state_t              state, state_nxt;
    logic [RCNT_W-1:0]   rst_cnt;
    logic                first_sd;
    logic [DLY_W-1:0]    prev_dly;
    logic                launch;
    logic [DLY_W-1:0]    speed_x10, dly, dly_diff;
    logic                hit, conv_hit;
    logic [7:0]          hit_cnt_nxt, run_cnt_nxt, step_mult;
    logic [SCAN_W:0]     scan_sum;
    logic [SCAN_W-1:0]   scan_nxt;

    // A new campaign may only be launched from IDLE or DONE; start while busy is dropped.
    assign launch = start && ((state == IDLE) || (state == DONE));

    assign speed_x10 = DLY_W'(speed) * DLY_W'(10);
    assign dly       = (speed > SPEED_W'(20)) ? speed_x10 + DLY_W'(1000)
                                              : speed_x10 + DLY_W'(900);
    assign dly_diff  = (dly >= prev_dly) ? dly - prev_dly : prev_dly - dly;
    assign hit       = (run_cnt != 8'd0) && (dly_diff <= DLY_W'(EPS));

    assign hit_cnt_nxt = (hit && (hit_cnt != 8'hFF)) ? hit_cnt + 8'd1 : hit_cnt;
    assign run_cnt_nxt = run_cnt + 8'd1;
    assign conv_hit    = (hit_cnt_nxt >= 8'(K_THRESH));

`ifdef BOUNCE_MULT_EN
    logic [7:0] mult, mult_nxt;

    assign mult_nxt  = !hit ? mult : (mult >= 8'd128) ? 8'd128 : {mult[6:0], 1'b0};
    assign step_mult = mult_nxt;

    // Increment multiplier: restarts at 1 per campaign, doubles on each hit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            mult <= 8'd1;
        else if (launch)
            mult <= 8'd1;
        else if (state == EVAL)
            mult <= mult_nxt;
    end
`else
    assign step_mult = 8'd1;
`endif

    // Next scan_num saturates instead of wrapping.
    assign scan_sum = {1'b0, scan_num} + (SCAN_W+1)'(SCAN_STEP * int'(step_mult));
    assign scan_nxt = scan_sum[SCAN_W] ? '1 : scan_sum[SCAN_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CUT_RST;
            CUT_RST: if (rst_cnt == '0) state_nxt = ARM;
            ARM:     if (!over) state_nxt = RUN;
            RUN:     if (over) state_nxt = EVAL;
            EVAL: begin
                if (conv_hit)
                    state_nxt = DONE;
                else if (run_cnt_nxt >= 8'(MAX_RUNS))
                    state_nxt = DONE;
                else
                    state_nxt = CUT_RST;
            end
            DONE:    if (start) state_nxt = CUT_RST;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cut_rst_n  <= 1'b1;
            scan_num   <= SCAN_W'(SCAN_START);
            pass       <= 1'b0;
            golden_sig <= '0;
            max_dly    <= '0;
            run_cnt    <= 8'd0;
            hit_cnt    <= 8'd0;
            busy       <= 1'b0;
            converged  <= 1'b0;
            done       <= 1'b0;
            rst_cnt    <= '0;
            first_sd   <= 1'b0;
            prev_dly   <= '0;
        end else begin
            if (launch) begin
                run_cnt   <= 8'd0;
                hit_cnt   <= 8'd0;
                converged <= 1'b0;
                done      <= 1'b0;
                prev_dly  <= '0;
                scan_num  <= SCAN_W'(SCAN_START);
                busy      <= 1'b1;
                cut_rst_n <= 1'b0;
                rst_cnt   <= RCNT_W'(RST_CYC - 1);
            end
            case (state)
                CUT_RST: begin
                    if (rst_cnt == '0) begin
                        cut_rst_n <= 1'b1;
                        first_sd  <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RCNT_W'(1);
                    end
                end
                RUN: begin
                    if (scan_done) begin
                        if (first_sd) begin
                            golden_sig <= sig;
                            pass       <= 1'b1;
                            first_sd   <= 1'b0;
                        end else begin
                            pass <= (sig == golden_sig);
                        end
                    end
                end
                EVAL: begin
                    max_dly  <= dly;
                    prev_dly <= dly;
                    hit_cnt  <= hit_cnt_nxt;
                    run_cnt  <= run_cnt_nxt;
                    scan_num <= scan_nxt;
                    if (state_nxt == DONE) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        converged <= conv_hit;
                    end else begin
                        cut_rst_n <= 1'b0;
                        rst_cnt   <= RCNT_W'(RST_CYC - 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_self_conv_seq.sv
// Testbench for self_conv_seq: campaign-level expectation model checked
// every cycle, plus literal expectations at key points.
module tb_self_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, over, scan_done;
    logic [12:0] sig;
    logic [9:0]  speed;
    logic        cut_rst_n, pass, busy, converged, done;
    logic [19:0] scan_num;
    logic [12:0] golden_sig;
    logic [15:0] max_dly;
    logic [7:0]  run_cnt, hit_cnt;

    always #5 clk = ~clk;

    self_conv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .over(over),
        .scan_done(scan_done), .sig(sig), .speed(speed),
        .cut_rst_n(cut_rst_n), .scan_num(scan_num), .pass(pass),
        .golden_sig(golden_sig), .max_dly(max_dly), .run_cnt(run_cnt),
        .hit_cnt(hit_cnt), .busy(busy), .converged(converged), .done(done)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // expected outputs after the next clock edge
    int e_cut, e_scan, e_pass, e_gold, e_dly, e_runs, e_hits, e_busy, e_conv, e_done;
    // campaign memory
    int m_prev, m_mult;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cut_rst_n",  int'(cut_rst_n),  e_cut);
            chk("scan_num",   int'(scan_num),   e_scan);
            chk("pass",       int'(pass),       e_pass);
            chk("golden_sig", int'(golden_sig), e_gold);
            chk("max_dly",    int'(max_dly),    e_dly);
            chk("run_cnt",    int'(run_cnt),    e_runs);
            chk("hit_cnt",    int'(hit_cnt),    e_hits);
            chk("busy",       int'(busy),       e_busy);
            chk("converged",  int'(converged),  e_conv);
            chk("done",       int'(done),       e_done);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        e_cut = 1; e_scan = 50; e_pass = 0; e_gold = 0; e_dly = 0;
        e_runs = 0; e_hits = 0; e_busy = 0; e_conv = 0; e_done = 0;
    endtask

    task automatic launch();
        start = 1'b1;
        e_busy = 1; e_cut = 0; e_scan = 50; e_runs = 0; e_hits = 0;
        e_conv = 0; e_done = 0; m_prev = 0; m_mult = 1;
        step();
        start = 1'b0;
    endtask

    // Outcome of one run given the captured speed code.
    task automatic model_eval(input int sp);
        int d, diff, inc;
        d = (sp > 20) ? 1000 + 10 * sp : 900 + 10 * sp;
        diff = (d > m_prev) ? d - m_prev : m_prev - d;
        if (e_runs > 0 && diff <= 10) begin
            if (e_hits < 255) e_hits++;
            m_mult = (m_mult * 2 > 128) ? 128 : m_mult * 2;
        end
`ifdef BOUNCE_MULT_EN
        inc = 10 * m_mult;
`else
        inc = 10;
`endif
        e_scan = (e_scan + inc > 20'hFFFFF) ? 20'hFFFFF : e_scan + inc;
        e_dly  = d;
        m_prev = d;
        e_runs++;
        if (e_hits >= 7) begin
            e_conv = 1; e_done = 1; e_busy = 0;
        end else if (e_runs >= 6) begin
            e_done = 1; e_busy = 0;
        end else begin
            e_cut = 0;
        end
    endtask

    // One run, entered on the cycle right after cut_rst_n has gone low.
    task automatic do_run(input int sp, input int n_sd, input logic [12:0] s0,
                          input logic [12:0] s1, input bit sd_with_over,
                          input int stale, input bit poke_start);
        if (poke_start) start = 1'b1;
        step();
        start = 1'b0;
        step();
        e_cut = 1;
        step();
        if (over) repeat (stale) step();
        over = 1'b0;
        step();
        for (int i = 0; i < n_sd; i++) begin
            scan_done = 1'b1;
            sig = (i == 0) ? s0 : s1;
            if (i == 0) begin
                e_gold = int'(s0); e_pass = 1;
            end else begin
                e_pass = (int'(s1) == e_gold) ? 1 : 0;
            end
            if (i == n_sd - 1 && sd_with_over) begin
                over = 1'b1; speed = 10'(sp);
            end
            step();
            scan_done = 1'b0;
        end
        if (!(n_sd > 0 && sd_with_over)) begin
            over = 1'b1; speed = 10'(sp);
            step();
        end
        model_eval(sp);
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; over = 1'b0; scan_done = 1'b0;
        sig = '0; speed = '0;
        model_reset();
        m_prev = 0; m_mult = 1;
        step(); step();
        chk_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("lit_reset_scan", int'(scan_num), 50);
        chk("lit_reset_cut", int'(cut_rst_n), 1);

        // campaign 1: six runs, one hit
        launch();
        chk("lit_start_cut", int'(cut_rst_n), 0);
        chk("lit_start_busy", int'(busy), 1);
        do_run(25, 2, 13'h0A5, 13'h0A4, 1'b1, 0, 1'b0);
        chk("lit_run1_dly", int'(max_dly), 1250);
        chk("lit_run1_gold", int'(golden_sig), 'h0A5);
        chk("lit_run1_pass", int'(pass), 0);
        chk("lit_run1_scan", int'(scan_num), 60);
        do_run(26, 1, 13'h111, 13'h000, 1'b0, 2, 1'b0);
        chk("lit_run2_dly", int'(max_dly), 1260);
        chk("lit_run2_hit", int'(hit_cnt), 1);
`ifdef BOUNCE_MULT_EN
        chk("lit_run2_scan", int'(scan_num), 80);
`else
        chk("lit_run2_scan", int'(scan_num), 70);
`endif
        do_run(20, 0, 13'h000, 13'h000, 1'b0, 1, 1'b1);
        chk("lit_run3_dly", int'(max_dly), 1100);
        do_run(21, 2, 13'h033, 13'h033, 1'b0, 1, 1'b0);
        chk("lit_run4_dly", int'(max_dly), 1210);
        chk("lit_run4_hit", int'(hit_cnt), 1);
        do_run(30, 1, 13'h044, 13'h000, 1'b0, 1, 1'b0);
        do_run(40, 1, 13'h055, 13'h000, 1'b0, 1, 1'b0);
        chk("lit_c1_done", int'(done), 1);
        chk("lit_c1_conv", int'(converged), 0);
        chk("lit_c1_runs", int'(run_cnt), 6);
        chk("lit_c1_busy", int'(busy), 0);
        repeat (3) step();

        // campaign 2 from DONE, aborted by reset during RUN
        launch();
        step(); step();
        e_cut = 1;
        step();
        over = 1'b0;
        step();
        scan_done = 1'b1; sig = 13'h01F; e_gold = 'h01F; e_pass = 1;
        step();
        scan_done = 1'b0;
        rst_n = 1'b0;
        model_reset();
        step();
        chk("lit_abort_scan", int'(scan_num), 50);
        chk("lit_abort_gold", int'(golden_sig), 0);
        chk("lit_abort_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();

        // campaign 3: identical speeds, hit on every run after the first
        launch();
        chk("lit_c3_scan", int'(scan_num), 50);
        for (int r = 0; r < 6; r++)
            do_run(50, 1, 13'h0AA, 13'h000, 1'b0, 1, 1'b0);
        chk("lit_c3_dly", int'(max_dly), 1500);
        chk("lit_c3_hit", int'(hit_cnt), 5);
        chk("lit_c3_conv", int'(converged), 0);
`ifdef BOUNCE_MULT_EN
        chk("lit_c3_scan_end", int'(scan_num), 680);
`else
        chk("lit_c3_scan_end", int'(scan_num), 110);
`endif
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
